uart_rx: RTL and testbench

- 8N1 UART receiver, the receive-side counterpart of the team's fixed-ratio UART transmitter.
- Oversamples the serial line at clk, with no separate baud enable; the default is 16 clocks per bit, matching the transmitter.
- Presents each received byte on a parallel register with a one-cycle done strobe.
- Flags framing errors. Sits between the board RX pin and the command/data parser.

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. Oversamples rx at clk (CLKS_PER_BIT clocks
//            per bit), centre-samples each bit, and presents every correctly
//            framed byte on rx_reg with a one-cycle rx_done strobe. A stop
//            bit sampled low gives a one-cycle frame_err strobe instead.
// Ports    : clk       - system clock, all logic on posedge
//            rst       - asynchronous active-high reset
//            rx        - serial line from the pin (asynchronous, idles high)
//            rx_reg    - last correctly framed byte
//            rx_done   - pulse: rx_reg updated this cycle
//            rx_busy   - high while a frame is in START/DATA/STOP
//            frame_err - pulse: stop bit sampled low
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_reg,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);

    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero  = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    localparam logic [2:0] c_st_wait_high = 3'd0;
    localparam logic [2:0] c_st_idle      = 3'd1;
    localparam logic [2:0] c_st_start     = 3'd2;
    localparam logic [2:0] c_st_data      = 3'd3;
    localparam logic [2:0] c_st_stop      = 3'd4;

    logic [1:0]         r_sync;
    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_reg;
    logic               r_done;
    logic               r_busy;
    logic               r_ferr;

    logic               w_rx_s;
    logic [2:0]         w_state_next;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic [2:0]         w_bit_idx_next;
    logic [7:0]         w_shift_next;
    logic [7:0]         w_rx_reg_next;
    logic               w_done_next;
    logic               w_busy_next;
    logic               w_ferr_next;

    assign w_rx_s = r_sync[1];

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= 2'b00;
            r_state   <= c_st_wait_high;
            r_cnt     <= c_cnt_zero;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_rx_reg  <= 8'h00;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_rx_reg  <= w_rx_reg_next;
            r_done    <= w_done_next;
            r_busy    <= w_busy_next;
            r_ferr    <= w_ferr_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + c_cnt_one;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_rx_reg_next  = r_rx_reg;
        w_done_next    = 1'b0;
        w_ferr_next    = 1'b0;

        case (r_state)
            c_st_wait_high: begin
                w_cnt_next = c_cnt_zero;
                if (w_rx_s) begin
                    w_state_next = c_st_idle;
                end
            end

            c_st_idle: begin
                w_cnt_next = c_cnt_zero;
                if (!w_rx_s) begin
                    // The cycle that sees the falling edge is sample 0 of the
                    // start bit, so counting resumes at 1 from here.
                    w_state_next = c_st_start;
                    w_cnt_next   = c_cnt_one;
                end
            end

            c_st_start: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_next     = c_cnt_zero;
                    w_bit_idx_next = 3'd0;
                    // Still low at mid-bit: a real start bit; else a glitch.
                    w_state_next   = w_rx_s ? c_st_idle : c_st_data;
                end
            end

            c_st_data: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_next     = c_cnt_zero;
                    w_shift_next   = {w_rx_s, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = c_st_stop;
                    end
                end
            end

            c_st_stop: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_next = c_cnt_zero;
                    if (w_rx_s) begin
                        w_rx_reg_next = r_shift;
                        w_done_next   = 1'b1;
                        w_state_next  = c_st_idle;
                    end else begin
                        // Line may be in break; wait for it to return high.
                        w_ferr_next  = 1'b1;
                        w_state_next = c_st_wait_high;
                    end
                end
            end

            default: begin
                w_cnt_next   = c_cnt_zero;
                w_state_next = c_st_wait_high;
            end
        endcase

        w_busy_next = (w_state_next == c_st_start) ||
                      (w_state_next == c_st_data)  ||
                      (w_state_next == c_st_stop);
    end

    assign rx_reg    = r_rx_reg;
    assign rx_done   = r_done;
    assign rx_busy   = r_busy;
    assign frame_err = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Frames are driven onto rx by a
//            bit-level transmitter; each complete frame posts an expected
//            event (cycle, byte, error flag) computed from the sample-instant
//            arithmetic, and a monitor matches every rx_done/frame_err pulse
//            against that event queue. A directed vector table, hand-written
//            corner sequences, random frames and a 256-byte loopback follow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CLKS_PER_BIT = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_reg;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_reg    (rx_reg),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       err;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       glitch;
        int         low_after;
        logic [7:0] exp_reg;
        int         exp_done;
        int         exp_err;
    } vec_t;

    int  n_vec = 0;
    int  n_mis = 0;
    int  cyc = 0;
    int  n_done = 0;
    int  n_err = 0;
    int  busy_run = 0;
    int  busy_cycles = 0;
    int  last_busy_len = 0;
    int  last_done_cyc = 0;
    ev_t exp_q[$];
    ev_t m_ev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pulses are matched in order against the expected-event queue.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (rx_busy) begin
                busy_run++;
                busy_cycles++;
            end else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run = 0;
            end
            if (rx_done || frame_err) begin
                if (rx_done) begin
                    n_done++;
                    last_done_cyc = cyc;
                end
                if (frame_err) n_err++;
                chk("done_err_exclusive", {31'b0, rx_done & frame_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'd1, 32'd0);
                end else begin
                    m_ev = exp_q.pop_front();
                    chk("event_kind", {31'b0, frame_err}, {31'b0, m_ev.err});
                    chk("event_cycle", cyc, m_ev.cyc);
                    if (rx_done) chk("event_data", {24'b0, rx_reg}, {24'b0, m_ev.data});
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pin change just after edge P reaches the FSM at edge P+3 (T); the stop
    // sample is at T + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT - 1, seen after that edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        ev_t e;
        e.cyc  = cyc + 3 + CLKS_PER_BIT / 2 + 9 * CLKS_PER_BIT - 1;
        e.data = d;
        e.err  = ~stop_b;
        exp_q.push_back(e);
        rx = 1'b0;
        hold(CLKS_PER_BIT);
        for (int k = 0; k < 8; k++) begin
            rx = d[k];
            hold(CLKS_PER_BIT);
        end
        rx = stop_b;
        hold(CLKS_PER_BIT);
    endtask

    initial begin : watchdog
        #(100_000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        vec_t       tbl[6];
        int         done_at[6];
        int         d0, e0, b0;
        logic [7:0] model_reg;
        logic [7:0] rd;
        logic       rs;
        int         rg, rl;
        logic [7:0] rst_byte;

        tbl[0] = '{8'hA5, 1'b1, 20, 1'b0, 0,   8'hA5, 1, 0};
        tbl[1] = '{8'h00, 1'b1, 5,  1'b0, 0,   8'h00, 1, 0};
        tbl[2] = '{8'hFF, 1'b1, 0,  1'b0, 0,   8'hFF, 1, 0};
        tbl[3] = '{8'h3C, 1'b1, 10, 1'b1, 0,   8'h3C, 1, 0};
        tbl[4] = '{8'h55, 1'b0, 10, 1'b0, 500, 8'h3C, 0, 1};
        tbl[5] = '{8'h81, 1'b1, 10, 1'b0, 0,   8'h81, 1, 0};

        rst = 1'b1;
        rx  = 1'b1;
        hold(5);
        chk("reset_rx_reg", {24'b0, rx_reg}, 32'd0);
        chk("reset_rx_done", {31'b0, rx_done}, 32'd0);
        chk("reset_rx_busy", {31'b0, rx_busy}, 32'd0);
        chk("reset_frame_err", {31'b0, frame_err}, 32'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            rx = 1'b1;
            hold(tbl[i].gap);
            d0 = n_done;
            e0 = n_err;
            if (tbl[i].glitch) begin
                rx = 1'b0;
                hold(4);
                rx = 1'b1;
                hold(30);
                chk("glitch_no_done", n_done - d0, 32'd0);
                chk("glitch_no_err", n_err - e0, 32'd0);
                n_vec++;
                if (last_busy_len < 7 || last_busy_len > 8) begin
                    n_mis++;
                    $display("FAIL glitch_busy_len: got %0d cycles, expected 7..8", last_busy_len);
                end
                hold(tbl[i].gap);
            end
            send_frame(tbl[i].data, tbl[i].stop);
            if (tbl[i].low_after > 0) begin
                rx = 1'b0;
                hold(tbl[i].low_after);
                rx = 1'b1;
            end
            done_at[i] = last_done_cyc;
            chk("vec_rx_reg", {24'b0, rx_reg}, {24'b0, tbl[i].exp_reg});
            chk("vec_done_count", n_done - d0, tbl[i].exp_done);
            chk("vec_err_count", n_err - e0, tbl[i].exp_err);
            if (i > 0 && tbl[i].gap == 0)
                chk("b2b_interval", done_at[i] - done_at[i-1], 10 * CLKS_PER_BIT);
        end

        // Reset during data bit 3 (a low bit) with the line held low
        rx = 1'b1;
        hold(10);
        rst_byte = 8'hF0;
        rx = 1'b0;
        hold(CLKS_PER_BIT);
        for (int k = 0; k < 3; k++) begin
            rx = rst_byte[k];
            hold(CLKS_PER_BIT);
        end
        rx = rst_byte[3];
        hold(CLKS_PER_BIT / 2);
        rst = 1'b1;
        hold(5);
        rst = 1'b0;
        d0 = n_done;
        e0 = n_err;
        b0 = busy_cycles;
        hold(100);
        chk("rst_mid_rx_reg", {24'b0, rx_reg}, 32'd0);
        chk("rst_mid_no_busy", busy_cycles - b0, 32'd0);
        chk("rst_mid_no_done", n_done - d0, 32'd0);
        chk("rst_mid_no_err", n_err - e0, 32'd0);
        rx = 1'b1;
        hold(10);
        send_frame(8'h7E, 1'b1);
        chk("after_rst_rx_reg", {24'b0, rx_reg}, 32'h7E);
        model_reg = 8'h7E;

        // Random frames, occasionally with a bad stop bit and a break
        for (int i = 0; i < 40; i++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 7) != 0);
            rg = $urandom_range(0, 4);
            rl = rs ? 0 : $urandom_range(0, 50);
            rx = 1'b1;
            hold(rg);
            d0 = n_done;
            e0 = n_err;
            send_frame(rd, rs);
            if (!rs) begin
                rx = 1'b0;
                hold(rl);
                rx = 1'b1;
                hold(2);
            end else begin
                model_reg = rd;
            end
            chk("rand_rx_reg", {24'b0, rx_reg}, {24'b0, model_reg});
            chk("rand_done_count", n_done - d0, rs ? 32'd1 : 32'd0);
            chk("rand_err_count", n_err - e0, rs ? 32'd0 : 32'd1);
        end

        // Loopback of 256 sequential bytes, back to back
        rx = 1'b1;
        hold(5);
        d0 = n_done;
        e0 = n_err;
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i), 1'b1);
            chk("loop_rx_reg", {24'b0, rx_reg}, i);
        end
        rx = 1'b1;
        hold(20);
        chk("loop_done_count", n_done - d0, 32'd256);
        chk("loop_err_count", n_err - e0, 32'd0);
        chk("pending_events", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
